// File: rtl/clic_reg_pkg.sv
// clic_reg_pkg: shared selector state encoding, ctrl width and level masking helper.
package clic_reg_pkg;
  localparam int CLIC_CTRL_W = 8;
  typedef enum logic [1:0] {SCAN, OFFER, CLAIM} sel_state_e;
  function automatic logic [CLIC_CTRL_W-1:0] clic_level(input logic [CLIC_CTRL_W-1:0] ctrl,
                                                        input logic [3:0] nlbits);
    logic [3:0] nl;
    nl = (nlbits > 4'(CLIC_CTRL_W)) ? 4'(CLIC_CTRL_W) : nlbits;
    return ctrl | ({CLIC_CTRL_W{1'b1}} >> nl);
  endfunction
endpackage

// File: rtl/clic_max_tree.sv
// clic_max_tree: picks the highest-ctrl eligible lane of a group; ties go to the lower id.
module clic_max_tree #(
  parameter int Lanes = 8,
  parameter int CtrlW = 8,
  parameter int SrcW  = 8
) (
  input  logic [Lanes*CtrlW-1:0] ctrl_i,
  input  logic [Lanes-1:0]       elig_i,
  input  logic [SrcW-1:0]        base_i,
  output logic                   valid_o,
  output logic [SrcW-1:0]        id_o,
  output logic [CtrlW-1:0]       ctrl_o
);
  logic             v;
  logic [SrcW-1:0]  id;
  logic [CtrlW-1:0] c;
  always_comb begin
    v  = 1'b0;
    id = base_i;
    c  = '0;
    for (int l = 0; l < Lanes; l++) begin
      if (elig_i[l] && (!v || ctrl_i[l*CtrlW +: CtrlW] > c)) begin
        v  = 1'b1;
        id = base_i | SrcW'(l);
        c  = ctrl_i[l*CtrlW +: CtrlW];
      end
    end
  end
  assign valid_o = v;
  assign id_o    = id;
  assign ctrl_o  = c;
endmodule

// File: rtl/clic_irq_sequencer.sv
// clic_irq_sequencer: sweeps sources Lanes per cycle, offers the best eligible one to the core
// and clears the pending bit of claimed edge-triggered sources.
module clic_irq_sequencer
  import clic_reg_pkg::*;
#(
  parameter int NumSrc = 256,
  parameter int Lanes  = 8,
  parameter int CtrlW  = CLIC_CTRL_W,
  parameter int SrcW   = $clog2(NumSrc)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumSrc-1:0]       ip_i,
  input  logic [NumSrc-1:0]       ie_i,
  input  logic [NumSrc*CtrlW-1:0] ctrl_i,
  input  logic [NumSrc-1:0]       shv_i,
  input  logic [NumSrc-1:0]       edge_i,
  input  logic [3:0]              nlbits_i,
  input  logic [CtrlW-1:0]        thresh_i,
  output logic                    irq_valid_o,
  input  logic                    irq_ready_i,
  output logic [SrcW-1:0]         irq_id_o,
  output logic [CtrlW-1:0]        irq_level_o,
  output logic                    irq_shv_o,
  output logic [NumSrc-1:0]       clr_de_o,
  output logic [NumSrc-1:0]       clr_d_o
);
  localparam int Groups = NumSrc / Lanes;
  localparam int LaneW  = $clog2(Lanes);
  localparam int IdxW   = (Groups > 1) ? $clog2(Groups) : 1;

  sel_state_e       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             best_v_q, best_v_d, shv_q, shv_d;
  logic [SrcW-1:0]  best_id_q, best_id_d, id_q, id_d;
  logic [CtrlW-1:0] best_ctrl_q, best_ctrl_d, level_q, level_d;
  logic [NumSrc-1:0] elig;
  logic             grp_v, keep_v, m_v, last;
  logic [SrcW-1:0]  grp_id, m_id;
  logic [CtrlW-1:0] grp_ctrl, m_ctrl;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NumSrc; i++)
      elig[i] = ip_i[i] & ie_i[i] & (clic_level(ctrl_i[i*CtrlW +: CtrlW], nlbits_i) > thresh_i);
  end

  clic_max_tree #(.Lanes(Lanes), .CtrlW(CtrlW), .SrcW(SrcW)) u_tree (
    .ctrl_i  (ctrl_i[idx_q*Lanes*CtrlW +: Lanes*CtrlW]),
    .elig_i  (elig[idx_q*Lanes +: Lanes]),
    .base_i  (SrcW'({idx_q, {LaneW{1'b0}}})),
    .valid_o (grp_v),
    .id_o    (grp_id),
    .ctrl_o  (grp_ctrl)
  );

  // The running best holds lower ids, so only a strictly larger ctrl replaces it.
  assign keep_v = best_v_q && idx_q != '0;
  assign m_v    = grp_v | keep_v;
  assign m_id   = (grp_v && (!keep_v || grp_ctrl > best_ctrl_q)) ? grp_id : best_id_q;
  assign m_ctrl = (grp_v && (!keep_v || grp_ctrl > best_ctrl_q)) ? grp_ctrl : best_ctrl_q;
  assign last   = idx_q == IdxW'(Groups - 1);

  assign irq_valid_o = (state_q == OFFER) && elig[id_q];
  assign irq_id_o    = id_q;
  assign irq_level_o = level_q;
  assign irq_shv_o   = shv_q;
  assign clr_d_o     = '0;

  always_comb begin
    clr_de_o = '0;
    if (state_q == CLAIM && edge_i[id_q]) clr_de_o[id_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_v_d    = best_v_q;
    best_id_d   = best_id_q;
    best_ctrl_d = best_ctrl_q;
    id_d        = id_q;
    level_d     = level_q;
    shv_d       = shv_q;
    case (state_q)
      SCAN: begin
        idx_d       = last ? '0 : idx_q + 1'b1;
        best_v_d    = last ? 1'b0 : m_v;
        best_id_d   = m_id;
        best_ctrl_d = m_ctrl;
        if (last && m_v) begin
          state_d = OFFER;
          id_d    = m_id;
          level_d = clic_level(m_ctrl, nlbits_i);
          shv_d   = shv_i[m_id];
        end
      end
      OFFER: begin
        idx_d    = '0;
        best_v_d = 1'b0;
        state_d  = !irq_valid_o ? SCAN : irq_ready_i ? CLAIM : OFFER;
      end
      default: begin
        idx_d    = '0;
        best_v_d = 1'b0;
        state_d  = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SCAN;
      idx_q       <= '0;
      best_v_q    <= 1'b0;
      best_id_q   <= '0;
      best_ctrl_q <= '0;
      id_q        <= '0;
      level_q     <= '0;
      shv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_v_q    <= best_v_d;
      best_id_q   <= best_id_d;
      best_ctrl_q <= best_ctrl_d;
      id_q        <= id_d;
      level_q     <= level_d;
      shv_q       <= shv_d;
    end
  end
endmodule

// File: tb/tb_clic_irq_sequencer.sv
// tb_clic_irq_sequencer: directed checks of selection, handshake, withdrawal and edge clears.
module tb_clic_irq_sequencer;
  logic         clk_i = 1'b0, rst_ni = 1'b0;
  logic [255:0] ip_i = '0, ie_i = '0, shv_i = '0, edge_i = '0;
  logic [2047:0] ctrl_i = '0;
  logic [3:0]   nlbits_i = 4'd8;
  logic [7:0]   thresh_i = '0;
  logic         irq_ready_i = 1'b0;
  logic         irq_valid_o, irq_shv_o;
  logic [7:0]   irq_id_o, irq_level_o;
  logic [255:0] clr_de_o, clr_d_o;
  int           tests = 0, fails = 0;
  logic         found;
  int           vcnt, ccnt;

  clic_irq_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ip_i(ip_i), .ie_i(ie_i), .ctrl_i(ctrl_i),
    .shv_i(shv_i), .edge_i(edge_i), .nlbits_i(nlbits_i), .thresh_i(thresh_i),
    .irq_valid_o(irq_valid_o), .irq_ready_i(irq_ready_i), .irq_id_o(irq_id_o),
    .irq_level_o(irq_level_o), .irq_shv_o(irq_shv_o), .clr_de_o(clr_de_o), .clr_d_o(clr_d_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input int id, input logic [7:0] c, input logic e);
    ip_i[id] = 1'b1;
    ie_i[id] = 1'b1;
    ctrl_i[id*8 +: 8] = c;
    edge_i[id] = e;
  endtask

  task automatic clear_all();
    ip_i = '0; ie_i = '0; ctrl_i = '0; edge_i = '0; shv_i = '0;
    nlbits_i = 4'd8; thresh_i = '0; irq_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic wait_offer(input string tag, input int budget);
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk_i);
      found = irq_valid_o;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_valid", 32'(irq_valid_o), 0);
    chk("rst_id", 32'(irq_id_o), 0);
    chk("rst_level", 32'(irq_level_o), 0);
    chk("rst_shv", 32'(irq_shv_o), 0);
    chk("rst_clr", 32'($countones(clr_de_o)), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    vcnt = 0; ccnt = 0;
    for (int n = 0; n < 96; n++) begin
      @(negedge clk_i);
      vcnt += int'(irq_valid_o);
      ccnt += $countones(clr_de_o);
    end
    chk("idle_valid", 32'(vcnt), 0);
    chk("idle_clr", 32'(ccnt), 0);

    // level-triggered: highest ctrl wins, no clear on claim, re-offered
    clear_all();
    set_src(5, 8'h40, 1'b0);
    set_src(200, 8'h90, 1'b0);
    shv_i[200] = 1'b1;
    do_reset();
    wait_offer("lvl_offer", 64);
    chk("lvl_id", 32'(irq_id_o), 200);
    chk("lvl_level", 32'(irq_level_o), 32'h90);
    chk("lvl_shv", 32'(irq_shv_o), 1);
    irq_ready_i = 1'b1;
    @(negedge clk_i);
    irq_ready_i = 1'b0;
    chk("lvl_noclr", 32'($countones(clr_de_o)), 0);
    chk("lvl_claim_valid", 32'(irq_valid_o), 0);
    wait_offer("lvl_reoffer", 64);
    chk("lvl_re_id", 32'(irq_id_o), 200);

    // edge-triggered tie: lower id first, one-cycle clear, then the other
    clear_all();
    set_src(3, 8'h80, 1'b1);
    set_src(17, 8'h80, 1'b1);
    do_reset();
    wait_offer("edge_offer", 64);
    chk("edge_id", 32'(irq_id_o), 3);
    irq_ready_i = 1'b1;
    @(negedge clk_i);
    irq_ready_i = 1'b0;
    chk("edge_clr3", 32'(clr_de_o[3]), 1);
    chk("edge_clr_cnt", 32'($countones(clr_de_o)), 1);
    chk("edge_d", 32'($countones(clr_d_o)), 0);
    ip_i[3] = 1'b0;
    @(negedge clk_i);
    chk("edge_clr_gone", 32'($countones(clr_de_o)), 0);
    wait_offer("edge_next", 64);
    chk("edge_id17", 32'(irq_id_o), 17);

    // nlbits masking and threshold withdrawal
    clear_all();
    set_src(9, 8'h30, 1'b1);
    nlbits_i = 4'd2;
    do_reset();
    wait_offer("th_offer", 64);
    chk("th_id", 32'(irq_id_o), 9);
    chk("th_level", 32'(irq_level_o), 32'h3F);
    thresh_i = 8'h40;
    #1;
    chk("th_drop", 32'(irq_valid_o), 0);
    @(negedge clk_i);
    thresh_i = 8'h00;
    #1;
    chk("th_left_offer", 32'(irq_valid_o), 0);

    // ie cleared while ready is high: no claim
    wait_offer("ie_offer", 64);
    chk("ie_id", 32'(irq_id_o), 9);
    ie_i[9] = 1'b0;
    irq_ready_i = 1'b1;
    #1;
    chk("ie_drop", 32'(irq_valid_o), 0);
    @(negedge clk_i);
    chk("ie_noclr", 32'($countones(clr_de_o)), 0);
    irq_ready_i = 1'b0;

    // reset during CLAIM drops the clear and the source is re-offered
    clear_all();
    set_src(4, 8'h50, 1'b1);
    do_reset();
    wait_offer("rc_offer", 64);
    chk("rc_id", 32'(irq_id_o), 4);
    irq_ready_i = 1'b1;
    @(negedge clk_i);
    irq_ready_i = 1'b0;
    chk("rc_clr", 32'(clr_de_o[4]), 1);
    rst_ni = 1'b0;
    #1;
    chk("rc_clr_drop", 32'($countones(clr_de_o)), 0);
    chk("rc_valid", 32'(irq_valid_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_offer("rc_reoffer", 64);
    chk("rc_re_id", 32'(irq_id_o), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
